// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, $zero specifier and the ID/EX control bundle.
package mips_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALUOP_WIDTH    = 4;
    localparam int CNT_WIDTH      = 16;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   alu_src;
        logic [ALUOP_WIDTH-1:0] alu_op;
    } ctrl_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs and execute-side outputs of the ID/EX register.
interface id_ex_stage_if;
    logic [mips_pkg::REG_ADDR_WIDTH-1:0] id_rs, id_rt, id_rd;
    logic                                id_uses_rt;
    logic [mips_pkg::DATA_WIDTH-1:0]     id_read_data1, id_read_data2, id_imm;
    logic                                id_reg_write, id_mem_read, id_mem_write;
    logic                                id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [mips_pkg::ALUOP_WIDTH-1:0]    id_alu_op;
    logic                                flush;
    logic [mips_pkg::REG_ADDR_WIDTH-1:0] ex_rs, ex_rt, ex_reg_dest;
    logic [mips_pkg::DATA_WIDTH-1:0]     ex_read_data1, ex_read_data2, ex_imm;
    logic                                ex_reg_write, ex_mem_read, ex_mem_write;
    logic                                ex_mem_to_reg, ex_alu_src;
    logic [mips_pkg::ALUOP_WIDTH-1:0]    ex_alu_op;
    logic                                stall;
    logic [mips_pkg::CNT_WIDTH-1:0]      stall_count;
    modport master (
        output id_rs, id_rt, id_rd, id_uses_rt, id_read_data1, id_read_data2, id_imm,
        output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
        output id_alu_op, flush,
        input  ex_rs, ex_rt, ex_reg_dest, ex_read_data1, ex_read_data2, ex_imm,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
        input  stall, stall_count
    );
    modport slave (
        input  id_rs, id_rt, id_rd, id_uses_rt, id_read_data1, id_read_data2, id_imm,
        input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
        input  id_alu_op, flush,
        output ex_rs, ex_rt, ex_reg_dest, ex_read_data1, ex_read_data2, ex_imm,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
        output stall, stall_count
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use detection; a taken branch suppresses the stall.
module hazard_detect
    import mips_pkg::*;
(
    input  logic                      i_ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
    input  logic                      i_id_uses_rt,
    input  logic                      i_flush,
    output logic                      o_hazard,
    output logic                      o_stall
);
    always_comb begin
        o_hazard = i_ex_mem_read && (i_ex_rt != REG_ZERO) &&
                   ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
        o_stall  = o_hazard && !i_flush;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and a saturating stall counter.
module id_ex_stage
    import mips_pkg::*;
(
    input logic         clk,
    input logic         reset,
    id_ex_stage_if.slave bus
);
    ctrl_t                     w_id_ctrl, r_ctrl;
    logic [REG_ADDR_WIDTH-1:0] r_rs, r_rt, r_dest;
    logic [DATA_WIDTH-1:0]     r_d1, r_d2, r_imm;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic                      w_hazard, w_stall, w_bubble;

    hazard_detect u_hazard (
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rt       (r_rt),
        .i_id_rs       (bus.id_rs),
        .i_id_rt       (bus.id_rt),
        .i_id_uses_rt  (bus.id_uses_rt),
        .i_flush       (bus.flush),
        .o_hazard      (w_hazard),
        .o_stall       (w_stall)
    );

    assign w_bubble  = w_hazard || bus.flush;
    assign w_id_ctrl = '{bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                         bus.id_mem_to_reg, bus.id_alu_src, bus.id_alu_op};

    // A bubble clears specifiers too, so it can never match in forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_bubble) begin
            r_ctrl <= '0;
            r_rs   <= '0;
            r_rt   <= '0;
            r_dest <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_imm  <= '0;
        end else begin
            r_ctrl <= w_id_ctrl;
            r_rs   <= bus.id_rs;
            r_rt   <= bus.id_rt;
            r_dest <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            r_d1   <= bus.id_read_data1;
            r_d2   <= bus.id_read_data2;
            r_imm  <= bus.id_imm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_stall && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
    end

    assign bus.ex_rs         = r_rs;
    assign bus.ex_rt         = r_rt;
    assign bus.ex_reg_dest   = r_dest;
    assign bus.ex_read_data1 = r_d1;
    assign bus.ex_read_data2 = r_d2;
    assign bus.ex_imm        = r_imm;
    assign bus.ex_reg_write  = r_ctrl.reg_write;
    assign bus.ex_mem_read   = r_ctrl.mem_read;
    assign bus.ex_mem_write  = r_ctrl.mem_write;
    assign bus.ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.ex_alu_src    = r_ctrl.alu_src;
    assign bus.ex_alu_op     = r_ctrl.alu_op;
    assign bus.stall         = w_stall;
    assign bus.stall_count   = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX register, hazard bubbles and stall counter.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if bus();
    id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    // c = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic        uses_rt;
        logic [31:0] d1, d2, imm;
        logic [5:0]  c;
        logic [3:0]  op;
    } instr_t;

    typedef struct packed {
        logic [4:0]  rs, rt, dest;
        logic [31:0] d1, d2, imm;
        logic        rw, mr, mw, m2r, as;
        logic [3:0]  op;
    } out_t;

    localparam logic [5:0] C_LW  = 6'b110110;
    localparam logic [5:0] C_ADD = 6'b100001;
    localparam logic [5:0] C_ADI = 6'b100010;
    localparam logic [5:0] C_SW  = 6'b001010;
    localparam logic [5:0] C_BEQ = 6'b000000;

    out_t q[$];
    int tests = 0;
    int fails = 0;

    function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic u, input logic [5:0] c, input logic [3:0] op);
        instr_t i;
        i.rs = rs; i.rt = rt; i.rd = rd; i.uses_rt = u; i.c = c; i.op = op;
        i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom;
        return i;
    endfunction

    function automatic out_t obs();
        return out_t'{bus.ex_rs, bus.ex_rt, bus.ex_reg_dest, bus.ex_read_data1, bus.ex_read_data2,
                      bus.ex_imm, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                      bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_alu_op};
    endfunction

    task automatic issue(input instr_t i, input logic bub, input logic fl);
        bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd; bus.id_uses_rt = i.uses_rt;
        bus.id_read_data1 = i.d1; bus.id_read_data2 = i.d2; bus.id_imm = i.imm;
        {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg,
         bus.id_alu_src, bus.id_reg_dst} = i.c;
        bus.id_alu_op = i.op;
        bus.flush = fl;
        q.push_back(bub ? out_t'('0) : out_t'{i.rs, i.rt, i.c[0] ? i.rd : i.rt, i.d1, i.d2, i.imm,
                                              i.c[5], i.c[4], i.c[3], i.c[2], i.c[1], i.op});
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t e;
        reset = 1'b1;
        issue(mk(0, 0, 0, 0, C_BEQ, 0), 1'b1, 1'b0);
        void'(q.pop_front());
        tests++;
        if (obs() !== out_t'('0)) begin fails++; $display("FAIL reset_outputs: got %h expected 0", obs()); end
        tests++;
        if (bus.stall_count !== 16'h0) begin fails++; $display("FAIL reset_count: got %h expected 0", bus.stall_count); end
        tick(); reset = 1'b0;
        issue(mk(3, 8, 0, 0, C_LW, 4'h2), 1'b0, 1'b0);
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL reset_prelw: got %h expected %h", obs(), e); end
        issue(mk(8, 10, 9, 1, C_ADD, 4'h2), 1'b1, 1'b0);
        tests++;
        if (bus.stall !== 1'b1) begin fails++; $display("FAIL reset_prestall: got %b expected 1", bus.stall); end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (obs() !== out_t'('0) || bus.stall !== 1'b0 || bus.stall_count !== 16'h0) begin
            fails++; $display("FAIL reset_async: got out=%h stall=%b cnt=%h expected all 0", obs(), bus.stall, bus.stall_count);
        end
        q.delete();
        tick(); reset = 1'b0;
    endtask

    task automatic test_load_use();
        out_t e;
        instr_t add;
        add = mk(8, 10, 9, 1, C_ADD, 4'h2);
        issue(mk(3, 8, 0, 0, C_LW, 4'h2), 1'b0, 1'b0);
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL lu_lw: got %h expected %h", obs(), e); end
        issue(add, 1'b1, 1'b0);
        tests++;
        if (bus.stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b expected 1", bus.stall); end
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL lu_bubble: got %h expected %h", obs(), e); end
        issue(add, 1'b0, 1'b0);
        tests++;
        if (bus.stall !== 1'b0) begin fails++; $display("FAIL lu_stall_len: got %b expected 0", bus.stall); end
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e || bus.ex_rs !== 5'd8) begin fails++; $display("FAIL lu_add: got %h expected %h", obs(), e); end
        tests++;
        if (bus.stall_count !== 16'd1) begin fails++; $display("FAIL lu_count: got %h expected 1", bus.stall_count); end
    endtask

    task automatic test_no_stall();
        out_t e;
        issue(mk(3, 8, 0, 0, C_LW, 4'h2), 1'b0, 1'b0);
        tick(); e = q.pop_front();
        issue(mk(3, 8, 0, 0, C_ADI, 4'h2), 1'b0, 1'b0);
        tests++;
        if (bus.stall !== 1'b0) begin fails++; $display("FAIL addi_stall: got %b expected 0", bus.stall); end
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL addi_pass: got %h expected %h", obs(), e); end
        issue(mk(4, 0, 0, 0, C_LW, 4'h2), 1'b0, 1'b0);
        tick(); e = q.pop_front();
        issue(mk(0, 0, 11, 1, C_ADD, 4'h2), 1'b0, 1'b0);
        tests++;
        if (bus.stall !== 1'b0) begin fails++; $display("FAIL zero_stall: got %b expected 0", bus.stall); end
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL zero_pass: got %h expected %h", obs(), e); end
    endtask

    task automatic test_flush_hazard();
        out_t e;
        logic [15:0] c0;
        issue(mk(3, 8, 0, 0, C_LW, 4'h2), 1'b0, 1'b0);
        tick(); e = q.pop_front();
        c0 = bus.stall_count;
        issue(mk(8, 10, 9, 1, C_ADD, 4'h2), 1'b1, 1'b1);
        tests++;
        if (bus.stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b expected 0", bus.stall); end
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL flush_bubble: got %h expected %h", obs(), e); end
        tests++;
        if (bus.stall_count !== c0) begin fails++; $display("FAIL flush_count: got %h expected %h", bus.stall_count, c0); end
        bus.flush = 1'b0;
    endtask

    task automatic test_pass_through();
        out_t e;
        for (int k = 0; k < 6; k++) begin
            issue(mk(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                     6'($urandom) & 6'b101111, 4'($urandom)), 1'b0, 1'b0);
            tick();
            e = q.pop_front(); tests++;
            if (obs() !== e) begin fails++; $display("FAIL pass_%0d: got %h expected %h", k, obs(), e); end
        end
    endtask

    task automatic test_back_to_back();
        out_t e;
        logic [15:0] c0;
        instr_t lw9, beq;
        lw9 = mk(8, 9, 0, 0, C_LW, 4'h2);
        beq = mk(1, 9, 0, 1, C_BEQ, 4'h6);
        c0 = bus.stall_count;
        issue(mk(3, 8, 0, 0, C_LW, 4'h2), 1'b0, 1'b0);
        tick(); e = q.pop_front();
        issue(lw9, 1'b1, 1'b0);
        tests++;
        if (bus.stall !== 1'b1) begin fails++; $display("FAIL b2b_stall1: got %b expected 1", bus.stall); end
        tick(); e = q.pop_front();
        issue(lw9, 1'b0, 1'b0);
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL b2b_lw9: got %h expected %h", obs(), e); end
        issue(beq, 1'b1, 1'b0);
        tests++;
        if (bus.stall !== 1'b1) begin fails++; $display("FAIL b2b_stall2: got %b expected 1", bus.stall); end
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL b2b_bubble: got %h expected %h", obs(), e); end
        issue(beq, 1'b0, 1'b0);
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e || bus.stall_count !== c0 + 16'd2) begin
            fails++; $display("FAIL b2b_beq: got %h cnt=%h expected %h cnt=%h", obs(), bus.stall_count, e, c0 + 16'd2);
        end
    endtask

    task automatic test_saturation();
        out_t e;
        instr_t ld;
        ld = mk(8, 8, 0, 0, C_LW, 4'h2);
        issue(mk(0, 0, 0, 0, C_BEQ, 0), 1'b0, 1'b0);
        tick(); e = q.pop_front();
        @(negedge clk);
        force dut.r_cnt = 16'hFFFE;
        #1 release dut.r_cnt;
        tests++;
        if (bus.stall_count !== 16'hFFFE) begin fails++; $display("FAIL sat_force: got %h expected fffe", bus.stall_count); end
        tick();
        issue(ld, 1'b0, 1'b0);
        tick(); e = q.pop_front();
        for (int k = 0; k < 3; k++) begin
            issue(ld, 1'b1, 1'b0);
            tick(); e = q.pop_front();
            tests++;
            if (obs() !== e || bus.stall_count !== 16'hFFFF) begin
                fails++; $display("FAIL sat_%0d: got %h cnt=%h expected %h cnt=ffff", k, obs(), bus.stall_count, e);
            end
            issue(ld, 1'b0, 1'b0);
            tick(); e = q.pop_front();
        end
    endtask

    task automatic test_store();
        out_t e;
        issue(mk(6, 5, 0, 1, C_SW, 4'h2), 1'b0, 1'b0);
        tick();
        e = q.pop_front(); tests++;
        if (obs() !== e) begin fails++; $display("FAIL sw_pass: got %h expected %h", obs(), e); end
        tests++;
        if (bus.ex_mem_write !== 1'b1 || bus.ex_rt !== 5'd5 || bus.ex_reg_write !== 1'b0) begin
            fails++; $display("FAIL sw_fields: got mw=%b rt=%0d rw=%b expected mw=1 rt=5 rw=0",
                              bus.ex_mem_write, bus.ex_rt, bus.ex_reg_write);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_flush_hazard();
        test_pass_through();
        test_back_to_back();
        test_saturation();
        test_store();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, sitting between decode and execute.
- Registers decoded operands, register specifiers and control bits, and feeds the forwarding logic: ex_rs/ex_rt drive rs_current/rt_current, ex_mem_write drives sw_detected.
- Inserts a one-cycle bubble on a load-use hazard, stalls PC and IF/ID, and squashes on a taken branch.
- Keeps a saturating stall counter for performance debug.

Parameters:
- DATA_WIDTH, 32, operand/immediate width
- REG_ADDR_WIDTH, 5, register specifier width
- ALUOP_WIDTH, 4, ALU operation code width
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- id_rs, id_rt, id_rd  in  REG_ADDR_WIDTH each  decode register specifiers
- id_uses_rt  in  1  instruction reads rt as a source (R-type, beq/bne, sw)
- id_read_data1, id_read_data2  in  DATA_WIDTH each  register file outputs
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each  decode control
- id_alu_op  in  ALUOP_WIDTH  decode ALU control
- flush  in  1  branch/jump taken; squash the decode instruction
- ex_rs, ex_rt, ex_reg_dest  out  REG_ADDR_WIDTH  registered specifiers; ex_reg_dest = rd if reg_dst else rt, selected before the register
- ex_read_data1, ex_read_data2, ex_imm  out  DATA_WIDTH  registered operands
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  out  1  registered control
- ex_alu_op  out  ALUOP_WIDTH  registered ALU control
- stall  out  1  combinational; hold PC and IF/ID this cycle
- stall_count  out  CNT_WIDTH  number of stall cycles, saturating

Behaviour:
- Reset: asynchronous and active-high. Every registered output is 0 and stall_count is 0. A reset mid-stall drops stall immediately, because the ex_mem_read it depends on clears.
- Hazard detection (combinational): hazard = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- stall = hazard && !flush. A taken branch squashes the dependent instruction, so no stall is needed.
- Normal cycle (no hazard, no flush): all id_* values are captured on the rising edge. Latency is 1 cycle.
- Bubble (hazard or flush): on the edge, all control outputs, ex_rs, ex_rt and ex_reg_dest load 0. Data outputs also load 0.
  - A bubble is therefore a no-op: no register write, no memory access, and it never matches in forwarding because the specifiers are 0.
- Stall length: after a bubble, ex_mem_read = 0. A stall therefore lasts exactly 1 cycle per load-use pair.
- Back-to-back loads: each dependent consumer stalls independently.
- Simultaneous flush and hazard: a bubble is inserted, stall = 0, and the counter does not increment.
- $zero: a load to $0 never stalls.
- stall_count: increments by 1 on each edge where stall = 1 and holds at all-ones, with no wrap-around.
- ex_mem_write is the store indicator consumed as sw_detected downstream. It is not gated by anything else.
- No enable from later stages: this stage never back-pressures and is never held by downstream.

Decomposition:
- Shared package mips_pkg holds:
  - width constants: DATA_WIDTH, REG_ADDR_WIDTH, ALUOP_WIDTH
  - REG_ZERO = 5'd0
  - a packed control-bundle typedef ctrl_t {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op}, so the bubble is a single assignment of '0.
- Natural sub-module: hazard_detect, purely combinational, computing hazard and stall from ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt and flush. It is instantiated once; the register and counter stay in id_ex_stage.

Test Plan:
- Reset asserted mid-transfer with ex_reg_write=1 -> all outputs 0 asynchronously, before the next edge; stall_count=0.
- lw $8 followed by add $9,$8,$10 (id_rs=8) -> stall=1 for exactly 1 cycle. The next ex_* is a bubble (all control 0, ex_rt=0). The add then enters with ex_rs=8; stall_count=1.
- lw $8 followed by addi $8,$3,4 (id_uses_rt=0, id_rt=8, id_rs=3) -> no stall; the instruction passes through in 1 cycle.
- lw $0 followed by add using $0 -> stall=0.
- Hazard and flush in the same cycle -> stall=0, a bubble is inserted, stall_count is unchanged.
- Force stall_count to 16'hFFFE, then apply 3 hazards -> the counter reads 16'hFFFF and stays there.
- sw $5,0($6) passes through -> ex_mem_write=1, ex_rt=5, ex_reg_write=0 one cycle after capture.
